fetch_sequencer: RTL

//   Sequences the program counter and instruction memory; the IF stage controller in front of decode.

---
 rtl/fetch_sequencer.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// IF-stage controller: issues one instruction-memory read per cycle, tags returned words
// with their PC, buffers them in a 2-entry queue and hands them to decode over valid/ready.
module fetch_sequencer #(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               im_req,
    output logic [PC_W-1:0]    im_addr,
    input  logic [INSTR_W-1:0] im_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               halt,
    output logic               id_valid,
    output logic [PC_W-1:0]    id_pc,
    output logic [INSTR_W-1:0] id_instr,
    input  logic               id_ready,
    output logic               halted
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [1:0]         count_q, count_d;
    logic               inflight_q, inflight_d;
    logic               kill_q, kill_d;

    logic [PC_W-1:0]    tag_q;
    logic [PC_W-1:0]    slot0_pc_q, slot1_pc_q;
    logic [INSTR_W-1:0] slot0_instr_q, slot1_instr_q;

    logic               pop, push, issue, redirect_act, wr_slot1;
    logic [2:0]         occupancy;
    logic [1:0]         unused_redirect_lsbs;

    assign unused_redirect_lsbs = redirect_pc[1:0];

    assign id_valid     = (count_q != 2'd0);
    assign pop          = id_valid & id_ready;
    assign redirect_act = redirect_valid & (state_q != S_IDLE);
    // Occupancy counts the word already in flight so the queue can never be overrun.
    assign occupancy    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue        = (state_q == S_RUN) & ~halt & ~redirect_act & (occupancy < 3'd2);
    assign push         = inflight_q & ~kill_q & ~redirect_act;
    assign wr_slot1     = (count_q == 2'd2) | ((count_q == 2'd1) & ~pop);

    assign im_req   = issue;
    assign im_addr  = pc_q;
    assign id_pc    = id_valid ? slot0_pc_q : '0;
    assign id_instr = id_valid ? slot0_instr_q : '0;
    assign halted   = (state_q == S_HALTED);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        count_d    = count_q - {1'b0, pop} + {1'b0, push};
        inflight_d = issue;
        kill_d     = 1'b0;

        case (state_q)
            S_IDLE:   state_d = S_RUN;
            S_RUN:    if (!redirect_act && halt && !inflight_q) state_d = S_HALTED;
            S_HALTED: if (!halt) state_d = S_RUN;
            default:  state_d = S_IDLE;
        endcase

        if (issue) pc_d = pc_q + PC_W'(4);

        if (redirect_act) begin
            pc_d    = {redirect_pc[PC_W-1:2], 2'b00};
            count_d = 2'd0;
            kill_d  = inflight_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    // Queue storage: slot0 is the head; a pop shifts slot1 down before any push lands.
    always_ff @(posedge clk) begin
        if (issue) tag_q <= pc_q;
        if (pop) begin
            slot0_pc_q    <= slot1_pc_q;
            slot0_instr_q <= slot1_instr_q;
        end
        if (push) begin
            if (wr_slot1) begin
                slot1_pc_q    <= tag_q;
                slot1_instr_q <= im_rdata;
            end else begin
                slot0_pc_q    <= tag_q;
                slot0_instr_q <= im_rdata;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == 2'd2)));

endmodule
